rr_network_switch: RTL

Parametrised N-input to 1-output packet-word switch with valid/ready handshakes on every port. Successor to the single-request combinational switch: it arbitrates simultaneous requests instead of zeroing the output. Arbitration is round-robin or fixed-priority, selected at run time. The block registers the winning word in one output stage and tags it with its source index. It sits between the per-port ingress logic and the shared egress link.

---
 rtl/switch_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 40 ++++
 rtl/rr_network_switch.sv | 79 +++++++
 3 files changed

// File: rtl/switch_pkg.sv
// Shared definitions for the round-robin packet-word switch: arbitration mode
// encodings and the source-index width helper.
package switch_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  localparam int MAX_PORTS = 16;
  localparam int SRC_W     = $clog2(MAX_PORTS);

  typedef logic [SRC_W-1:0] src_idx_t;

  // Index width for an n-port switch; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way arbiter: round-robin starting at ptr, or fixed priority
// where the lowest index wins. Produces a one-hot grant and its index.
module rr_arbiter
  import switch_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             mode,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W:0] scan;

  // Loops run from the far end so the first matching requester is the last write.
  always_comb begin
    grant_idx = '0;
    scan      = '0;
    if (mode == MODE_FIXED) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req[i]) grant_idx = IDX_W'(i);
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        scan = {1'b0, ptr} + (IDX_W + 1)'(k);
        if (scan >= (IDX_W + 1)'(N)) scan = scan - (IDX_W + 1)'(N);
        if (req[scan[IDX_W-1:0]]) grant_idx = scan[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    grant = '0;
    if (|req) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/rr_network_switch.sv
// N-input to 1-output packet-word switch with a single registered output stage,
// run-time selectable round-robin / fixed-priority arbitration and a contention counter.
module rr_network_switch
  import switch_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       prio_mode,
  input  logic [N_PORTS-1:0]         in_valid,
  input  logic [DATA_W-1:0]          in_data [N_PORTS],
  output logic [N_PORTS-1:0]         in_ready,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(N_PORTS)-1:0] out_src,
  input  logic                       out_ready,
  output logic [CNT_W-1:0]           contention_cnt
);

  localparam int IDX_W = $clog2(N_PORTS);

  // Handshake contract: a channel transfers when in_valid[i] && in_ready[i].
  // in_ready is a function of in_valid and the output stage's load condition;
  // requesters must hold in_valid/in_data until accepted and must not wait on in_ready.

  logic [IDX_W-1:0]   rr_ptr;
  logic [N_PORTS-1:0] grant;
  logic [IDX_W-1:0]   winner;
  logic               load;
  logic               any_valid;
  logic               xfer;
  logic               contended;

  rr_arbiter #(
    .N     (N_PORTS),
    .IDX_W (IDX_W)
  ) u_arb (
    .req       (in_valid),
    .ptr       (rr_ptr),
    .mode      (prio_mode),
    .grant     (grant),
    .grant_idx (winner)
  );

  assign load      = !out_valid || out_ready;
  assign any_valid = |in_valid;
  assign xfer      = rst_n && load && any_valid;
  // Two or more requesters present: clearing the lowest set bit leaves something.
  assign contended = (in_valid & (in_valid - 1'b1)) != '0;
  assign in_ready  = xfer ? grant : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_src        <= '0;
      rr_ptr         <= '0;
      contention_cnt <= '0;
    end else begin
      if (load) begin
        out_valid <= any_valid;
        if (any_valid) begin
          out_data <= in_data[winner];
          out_src  <= winner;
        end
      end
      if (xfer && prio_mode == MODE_RR) begin
        rr_ptr <= (winner == IDX_W'(N_PORTS - 1)) ? '0 : winner + 1'b1;
      end
      if (xfer && contended && contention_cnt != '1) begin
        contention_cnt <= contention_cnt + 1'b1;
      end
    end
  end

endmodule
